manchester_frame_ctrl: RTL and testbench
========================================

# manchester_frame_ctrl

Frame-level controller for the Manchester receive path. It sequences the decoder between preamble hunt and byte assembly, latches the detected bit phase, and counts FRAME_SIZE payload bytes per frame. Frames are buffered in a small FIFO and emitted as AXI-Stream with tlast and an error flag. It sits between the Manchester decoder datapath and the downstream byte consumer, and absorbs consumer backpressure, which the decoder cannot.

## Interface
Parameters:
- FRAME_SIZE, 4: payload bytes per frame, ≥1.
- FIFO_DEPTH, 8: output FIFO entries, power of two, ≥ FRAME_SIZE.
- IDLE_TIMEOUT, 64: consecutive DATA cycles without a byte before abort, ≥2.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- dec_sync  in  1  decoder matched preamble+SFD (0xAAD5) this cycle.
- dec_phase  in  1  sample phase of that match (0/1).
- dec_byte_valid  in  1  decoder delivers one byte this cycle.
- dec_byte  in  8  decoded byte.
- dec_code_err  in  1  byte contained a non-transition Manchester pair.
- dec_hunt  out  1  1 = decoder searches for sync; 0 = decoder assembles bytes.
- dec_phase_sel  out  1  latched phase the decoder uses while assembling.
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- m_axis_tdata  out  8.
- m_axis_tlast  out  1  last beat of a frame.
- m_axis_tuser  out  1  frame error; meaningful only with tlast.
- stat_frames  out  16  frames completed, including padded ones; saturating.
- stat_drops  out  16  frames skipped or discarded; saturating.

## Operation
- States: HUNT, DATA. Reset → HUNT.
- HUNT: dec_hunt=1. dec_byte_valid is ignored.
  - On dec_sync with FIFO occupancy ≤ FIFO_DEPTH−FRAME_SIZE: latch dec_phase into dec_phase_sel, clear byte_cnt, idle_cnt and err_acc, then go to DATA.
  - On dec_sync with insufficient space: stat_drops+1, stay in HUNT, phase unchanged.
- Admission reserves a full frame of space, so a FIFO push never meets a full FIFO.
- DATA: dec_hunt=0. dec_sync is ignored, because payload can alias the sync word.
- On dec_byte_valid:
  - Push {dec_byte, last=(byte_cnt==FRAME_SIZE−1), user=last & (err_acc|dec_code_err)}.
  - err_acc |= dec_code_err; byte_cnt+1; idle_cnt cleared.
  - If last: stat_frames+1, go to HUNT.
- Without a byte: idle_cnt+1. When it reaches IDLE_TIMEOUT:
  - byte_cnt==0: stat_drops+1, go to HUNT, nothing pushed.
  - byte_cnt>0: push pad {0x00, last=1, user=1}, stat_frames+1, go to HUNT.
- HUNT with simultaneous dec_sync and dec_byte_valid: sync wins and the byte is dropped.
- FIFO: first-word-fall-through; entries are 10 bits wide.
  - tvalid = !empty; pop on tvalid & tready.
  - Push and pop in the same cycle are both honoured.
- AXI rules:
  - tdata, tlast and tuser stay stable while tvalid & !tready.
  - tdata, tlast and tuser are forced to 0 while tvalid=0.
- Counters saturate at 0xFFFF; no wrap.
- Widths:
  - byte_cnt: $clog2(FRAME_SIZE) bits, minimum 1.
  - occupancy: $clog2(FIFO_DEPTH)+1 bits.
  - idle_cnt: $clog2(IDLE_TIMEOUT+1) bits.
- Reset, asynchronous:
  - State and control: state=HUNT, dec_hunt=1, dec_phase_sel=0.
  - FIFO: empty.
  - AXI outputs: tvalid=0, tdata=0, tlast=0, tuser=0.
  - Statistics: stat_frames=0, stat_drops=0.
- Reset mid-frame discards FIFO contents and the partial frame; no tlast is emitted for it.

## Timing
- dec_sync at cycle N → dec_hunt=0 and dec_phase_sel valid at N+1.
- dec_byte_valid at N into an empty FIFO → m_axis_tvalid=1 at N+1, with that byte.
- Last byte at N → dec_hunt=1 and stat_frames updated at N+1. A dec_sync at N+1 is accepted.
- Timeout abort is taken on the IDLE_TIMEOUT-th consecutive byteless DATA cycle; HUNT from the next cycle.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package manchester_pkg:
  - state enum {HUNT, DATA};
  - SYNC_WORD=16'hAAD5;
  - FIFO entry width constant (10);
  - entry field offsets (data[7:0], last[8], user[9]).
- Sub-module manchester_frame_fifo:
  - synchronous FWFT FIFO, parameterised width and depth;
  - exposes occupancy;
  - same aclk and areset.
- Controller FSM, counters and statistics live in the top.

## Test plan
- Clean frame: sync with phase 1, then bytes 0x11,0x22,0x33,0x44 with tready=1 → dec_phase_sel=1; four beats, tlast on 0x44, tuser=0; stat_frames=1.
- Code error: the same frame with dec_code_err on byte 2 → tuser=1 on the tlast beat only.
- Backpressure/admission: FRAME_SIZE=4, FIFO_DEPTH=8, tready=0; three syncs, each followed by 4 bytes → first two frames buffered; third sync skipped, stat_drops=1; 8 beats drain in order once tready=1.
- Timeout: sync, 2 bytes, then silence for 64 cycles → beats b0, b1, then 0x00 with tlast=1 and tuser=1; dec_hunt=1 afterwards.
- Empty timeout and sync aliasing: sync, then no bytes for 64 cycles → no output, stat_drops+1. Separately, dec_sync pulses during DATA → ignored, byte_cnt unaffected.
- Reset mid-frame: areset asserted after 2 bytes, with FIFO non-empty and tready=0 → tvalid=0 and dec_hunt=1 immediately; no tlast ever emitted; counters read 0.

Source files
------------

// File: rtl/manchester_pkg.sv
// Shared types and constants for the Manchester receive frame controller.
package manchester_pkg;

   // Controller states: hunt for sync, or assemble payload bytes.
   typedef enum logic {
      HUNT = 1'b0,
      DATA = 1'b1
   } state_t;

   // Preamble + SFD the decoder matches before raising dec_sync.
   localparam logic [15:0] SYNC_WORD = 16'hAAD5;

   // Output FIFO entry layout: {user, last, data[7:0]}.
   localparam int unsigned ENTRY_W  = 10;
   localparam int unsigned DATA_LSB = 0;
   localparam int unsigned DATA_MSB = 7;
   localparam int unsigned LAST_BIT = 8;
   localparam int unsigned USER_BIT = 9;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [7:0] data,
                                                     input logic       last,
                                                     input logic       user);
      logic [ENTRY_W-1:0] e;
      e                    = '0;
      e[DATA_MSB:DATA_LSB] = data;
      e[LAST_BIT]          = last;
      e[USER_BIT]          = user;
      return e;
   endfunction

endpackage

// File: rtl/manchester_frame_ctrl_if.sv
// AXI-Stream byte channel carrying frames out of the controller.
interface manchester_frame_ctrl_if;

   logic       tvalid;
   logic       tready;
   logic [7:0] tdata;
   logic       tlast;
   logic       tuser;

   modport master (
      output tvalid,
      output tdata,
      output tlast,
      output tuser,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tlast,
      input  tuser,
      output tready
   );

endinterface

// File: rtl/manchester_frame_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module manchester_frame_fifo
   import manchester_pkg::*;
#(
   parameter int unsigned WIDTH = ENTRY_W,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             full;
   logic             do_push, do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign rdata     = mem[rd_ptr_q];
   assign occupancy = count_q;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage array; contents need no reset since reads are gated by empty.
   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/manchester_frame_ctrl.sv
// Frame controller: sequences the decoder, assembles frames into a FIFO and
// emits them as AXI-Stream with tlast and a per-frame error flag.
module manchester_frame_ctrl
   import manchester_pkg::*;
#(
   parameter int unsigned FRAME_SIZE   = 4,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned IDLE_TIMEOUT = 64
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    dec_sync,
   input  logic                    dec_phase,
   input  logic                    dec_byte_valid,
   input  logic [7:0]              dec_byte,
   input  logic                    dec_code_err,
   output logic                    dec_hunt,
   output logic                    dec_phase_sel,
   manchester_frame_ctrl_if.master m_axis,
   output logic [15:0]             stat_frames,
   output logic [15:0]             stat_drops
);

   localparam int unsigned BW    = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned IW    = $clog2(IDLE_TIMEOUT + 1);

   state_t               state_q, state_d;
   logic                 phase_q, phase_d;
   logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
   logic [IW-1:0]        idle_cnt_q, idle_cnt_d, idle_inc;
   logic                 err_acc_q, err_acc_d;
   logic [15:0]          frames_q, drops_q;
   logic                 frame_inc, drop_inc;

   logic                 push;
   logic [ENTRY_W-1:0]   wdata;
   logic [ENTRY_W-1:0]   rdata;
   logic                 empty;
   logic [OCC_W-1:0]     occupancy;
   logic                 room, is_last;

   manchester_frame_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk      (aclk),
      .areset    (areset),
      .push      (push),
      .wdata     (wdata),
      .pop       (m_axis.tready & ~empty),
      .rdata     (rdata),
      .empty     (empty),
      .occupancy (occupancy)
   );

   // Admit a frame only if a whole frame still fits, so pushes never overflow.
   assign room     = (occupancy <= OCC_W'(FIFO_DEPTH - FRAME_SIZE));
   assign is_last  = (byte_cnt_q == BW'(FRAME_SIZE - 1));
   assign idle_inc = idle_cnt_q + 1'b1;

   // Next-state, FIFO push and statistic increments.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      byte_cnt_d = byte_cnt_q;
      idle_cnt_d = idle_cnt_q;
      err_acc_d  = err_acc_q;
      push       = 1'b0;
      wdata      = '0;
      frame_inc  = 1'b0;
      drop_inc   = 1'b0;
      case (state_q)
         HUNT: begin
            // Bytes are ignored here; sync wins over a coincident byte.
            if (dec_sync) begin
               if (room) begin
                  state_d    = DATA;
                  phase_d    = dec_phase;
                  byte_cnt_d = '0;
                  idle_cnt_d = '0;
                  err_acc_d  = 1'b0;
               end else begin
                  drop_inc = 1'b1;
               end
            end
         end
         DATA: begin
            // dec_sync ignored: payload can alias the sync word.
            if (dec_byte_valid) begin
               push       = 1'b1;
               wdata      = pack_entry(dec_byte, is_last,
                                       is_last & (err_acc_q | dec_code_err));
               err_acc_d  = err_acc_q | dec_code_err;
               byte_cnt_d = byte_cnt_q + 1'b1;
               idle_cnt_d = '0;
               if (is_last) begin
                  frame_inc  = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = HUNT;
               end
            end else begin
               idle_cnt_d = idle_inc;
               if (idle_inc == IW'(IDLE_TIMEOUT)) begin
                  state_d = HUNT;
                  if (byte_cnt_q == '0) begin
                     drop_inc = 1'b1;
                  end else begin
                     // Close the partial frame with an errored pad beat.
                     push      = 1'b1;
                     wdata     = pack_entry(8'h00, 1'b1, 1'b1);
                     frame_inc = 1'b1;
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Controller state and counters.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= HUNT;
         phase_q    <= 1'b0;
         byte_cnt_q <= '0;
         idle_cnt_q <= '0;
         err_acc_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         byte_cnt_q <= byte_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         err_acc_q  <= err_acc_d;
      end
   end

   // Saturating frame and drop statistics.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         frames_q <= '0;
         drops_q  <= '0;
      end else begin
         if (frame_inc && frames_q != 16'hFFFF) frames_q <= frames_q + 1'b1;
         if (drop_inc && drops_q != 16'hFFFF)   drops_q  <= drops_q + 1'b1;
      end
   end

   assign dec_hunt      = (state_q == HUNT);
   assign dec_phase_sel = phase_q;
   assign stat_frames   = frames_q;
   assign stat_drops    = drops_q;

   // Payload fields are held at zero whenever no beat is offered.
   assign m_axis.tvalid = ~empty;
   assign m_axis.tdata  = empty ? 8'h00 : rdata[DATA_MSB:DATA_LSB];
   assign m_axis.tlast  = empty ? 1'b0 : rdata[LAST_BIT];
   assign m_axis.tuser  = empty ? 1'b0 : rdata[USER_BIT];

endmodule

// File: tb/tb_manchester_frame_ctrl.sv
// Self-checking bench for manchester_frame_ctrl with a frame-level reference model.
module tb_manchester_frame_ctrl;

   localparam int unsigned FS = 4;
   localparam int unsigned FD = 8;
   localparam int unsigned TO = 64;

   logic        aclk = 1'b0;
   logic        areset;
   logic        dec_sync, dec_phase, dec_byte_valid, dec_code_err;
   logic [7:0]  dec_byte;
   logic        dec_hunt, dec_phase_sel;
   logic [15:0] stat_frames, stat_drops;

   manchester_frame_ctrl_if m_axis ();

   manchester_frame_ctrl #(
      .FRAME_SIZE   (FS),
      .FIFO_DEPTH   (FD),
      .IDLE_TIMEOUT (TO)
   ) dut (
      .aclk           (aclk),
      .areset         (areset),
      .dec_sync       (dec_sync),
      .dec_phase      (dec_phase),
      .dec_byte_valid (dec_byte_valid),
      .dec_byte       (dec_byte),
      .dec_code_err   (dec_code_err),
      .dec_hunt       (dec_hunt),
      .dec_phase_sel  (dec_phase_sel),
      .m_axis         (m_axis),
      .stat_frames    (stat_frames),
      .stat_drops     (stat_drops)
   );

   always #5 aclk = ~aclk;

   int          vectors    = 0;
   int          miscompares = 0;
   logic [9:0]  exp_q [$];
   int          exp_frames = 0;
   int          exp_drops  = 0;
   bit          rand_ready = 0;

   // Output monitor: scoreboard of beats, stall stability and idle zeroing.
   logic        prev_stall = 1'b0;
   logic [9:0]  prev_beat, beat, e;
   always @(negedge aclk) begin
      beat = {m_axis.tuser, m_axis.tlast, m_axis.tdata};
      if (areset !== 1'b0) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            vectors++;
            if (m_axis.tvalid !== 1'b1 || beat !== prev_beat) begin
               miscompares++;
               $display("FAIL stall_stable: got valid=%b beat=%h, need valid=1 beat=%h",
                        m_axis.tvalid, beat, prev_beat);
            end
         end
         if (m_axis.tvalid === 1'b1) begin
            if (m_axis.tready === 1'b1) begin
               prev_stall = 1'b0;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_beat: got %h, need no beat", beat);
               end else begin
                  e = exp_q.pop_front();
                  if (beat !== e) begin
                     miscompares++;
                     $display("FAIL beat: got {user,last,data}=%h, need %h", beat, e);
                  end
               end
            end else begin
               prev_stall = 1'b1;
               prev_beat  = beat;
            end
         end else begin
            prev_stall = 1'b0;
            vectors++;
            if (beat !== 10'h000) begin
               miscompares++;
               $display("FAIL idle_zero: got %h with tvalid=0, need 000", beat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
      if (rand_ready) m_axis.tready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_sync(input logic ph, input logic with_byte);
      dec_sync       = 1'b1;
      dec_phase      = ph;
      dec_byte_valid = with_byte;
      dec_byte       = 8'($urandom);
      tick();
      dec_sync       = 1'b0;
      dec_byte_valid = 1'b0;
   endtask

   task automatic do_byte(input logic [7:0] b, input logic err, input logic alias_sync);
      dec_byte_valid = 1'b1;
      dec_byte       = b;
      dec_code_err   = err;
      dec_sync       = alias_sync;
      dec_phase      = 1'b1;
      tick();
      dec_byte_valid = 1'b0;
      dec_code_err   = 1'b0;
      dec_sync       = 1'b0;
   endtask

   task automatic do_idle(input int n, input bit alias_rand);
      for (int i = 0; i < n; i++) begin
         dec_sync  = alias_rand ? 1'($urandom_range(0, 1)) : 1'b0;
         dec_phase = 1'($urandom);
         tick();
      end
      dec_sync = 1'b0;
   endtask

   // Waits (bounded) for the scoreboard to empty with tready held high.
   task automatic drain();
      rand_ready    = 0;
      m_axis.tready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
   endtask

   // Expected beat list for a frame of bytes, computed from the framing rules.
   task automatic expect_frame(input logic [7:0] b[], input logic er[], input int n);
      logic any_err;
      any_err = 1'b0;
      for (int i = 0; i < n; i++) begin
         any_err = any_err | er[i];
         exp_q.push_back({(i == FS - 1) && any_err, (i == FS - 1), b[i]});
      end
      if (n < FS && n > 0) exp_q.push_back({1'b1, 1'b1, 8'h00});
   endtask

   task automatic test_reset();
      areset = 1'b1;
      dec_sync = 0; dec_phase = 0; dec_byte_valid = 0; dec_byte = 0; dec_code_err = 0;
      m_axis.tready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      vectors++;
      if ({dec_hunt, dec_phase_sel, m_axis.tvalid, m_axis.tdata, m_axis.tlast, m_axis.tuser}
          !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_ctrl: got hunt=%b ph=%b v=%b d=%h l=%b u=%b, need 1 0 0 00 0 0",
                  dec_hunt, dec_phase_sel, m_axis.tvalid, m_axis.tdata, m_axis.tlast,
                  m_axis.tuser);
      end
      vectors++;
      if (stat_frames !== 16'd0 || stat_drops !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_stats: got %0d/%0d, need 0/0", stat_frames, stat_drops);
      end
      areset = 1'b0;
      tick();
   endtask

   task automatic test_clean_frame(input bit with_err);
      logic [7:0] b[];
      logic       er[];
      b  = '{8'h11, 8'h22, 8'h33, 8'h44};
      er = '{1'b0, 1'b0, with_err, 1'b0};
      m_axis.tready = 1'b1;
      do_sync(1'b1, 1'b0);
      vectors++;
      if (dec_hunt !== 1'b0 || dec_phase_sel !== 1'b1) begin
         miscompares++;
         $display("FAIL sync_accept: got hunt=%b ph=%b, need 0 1", dec_hunt, dec_phase_sel);
      end
      expect_frame(b, er, FS);
      for (int i = 0; i < FS; i++) do_byte(b[i], er[i], 1'b0);
      exp_frames++;
      vectors++;
      if (dec_hunt !== 1'b1 || stat_frames !== 16'(exp_frames)) begin
         miscompares++;
         $display("FAIL frame_end: got hunt=%b frames=%0d, need 1 %0d",
                  dec_hunt, stat_frames, exp_frames);
      end
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_clean: got %0d beats pending, need 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] b[];
      logic       er[];
      er = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_axis.tready = 1'b0;
      for (int f = 0; f < 3; f++) begin
         b = '{8'(8'hA0 + f * 4), 8'(8'hA1 + f * 4), 8'(8'hA2 + f * 4), 8'(8'hA3 + f * 4)};
         do_sync(1'b0, 1'b0);
         if (f < 2) begin
            expect_frame(b, er, FS);
            exp_frames++;
         end else begin
            exp_drops++;
         end
         for (int i = 0; i < FS; i++) do_byte(b[i], 1'b0, 1'b0);
      end
      vectors++;
      if (stat_drops !== 16'(exp_drops) || stat_frames !== 16'(exp_frames)) begin
         miscompares++;
         $display("FAIL admission: got drops=%0d frames=%0d, need %0d %0d",
                  stat_drops, stat_frames, exp_drops, exp_frames);
      end
      vectors++;
      if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 8'hA0) begin
         miscompares++;
         $display("FAIL held_head: got v=%b d=%h, need 1 a0", m_axis.tvalid, m_axis.tdata);
      end
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_bp: got %0d beats pending, need 0", exp_q.size());
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b[];
      logic       er[];
      b  = '{8'h5C, 8'hC5, 8'h00, 8'h00};
      er = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_axis.tready = 1'b1;
      do_sync(1'b0, 1'b0);
      expect_frame(b, er, 2);
      do_byte(b[0], 1'b0, 1'b0);
      do_byte(b[1], 1'b0, 1'b0);
      do_idle(TO - 1, 0);
      vectors++;
      if (dec_hunt !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_early: got hunt=%b after %0d idle, need 0", dec_hunt, TO - 1);
      end
      do_idle(1, 0);
      exp_frames++;
      vectors++;
      if (dec_hunt !== 1'b1 || stat_frames !== 16'(exp_frames)) begin
         miscompares++;
         $display("FAIL timeout_pad: got hunt=%b frames=%0d, need 1 %0d",
                  dec_hunt, stat_frames, exp_frames);
      end
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_to: got %0d beats pending, need 0", exp_q.size());
      end
   endtask

   task automatic test_empty_timeout_alias();
      logic [7:0] b[];
      logic       er[];
      b  = '{8'hAA, 8'hD5, 8'hAA, 8'hD5};
      er = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_axis.tready = 1'b1;
      do_sync(1'b1, 1'b0);
      do_idle(TO, 0);
      exp_drops++;
      vectors++;
      if (dec_hunt !== 1'b1 || stat_drops !== 16'(exp_drops)) begin
         miscompares++;
         $display("FAIL empty_timeout: got hunt=%b drops=%0d, need 1 %0d",
                  dec_hunt, stat_drops, exp_drops);
      end
      do_sync(1'b0, 1'b0);
      expect_frame(b, er, FS);
      do_byte(b[0], 1'b0, 1'b0);
      dec_sync  = 1'b1;
      dec_phase = 1'b1;
      tick();
      dec_sync  = 1'b0;
      vectors++;
      if (dec_hunt !== 1'b0 || dec_phase_sel !== 1'b0) begin
         miscompares++;
         $display("FAIL alias_ignored: got hunt=%b ph=%b, need 0 0", dec_hunt, dec_phase_sel);
      end
      do_byte(b[1], 1'b0, 1'b1);
      do_byte(b[2], 1'b0, 1'b1);
      do_byte(b[3], 1'b0, 1'b0);
      exp_frames++;
      vectors++;
      if (dec_hunt !== 1'b1 || stat_frames !== 16'(exp_frames)) begin
         miscompares++;
         $display("FAIL alias_count: got hunt=%b frames=%0d, need 1 %0d",
                  dec_hunt, stat_frames, exp_frames);
      end
      drain();
   endtask

   task automatic test_random();
      logic [7:0] b[];
      logic       er[];
      logic       ph;
      int         n;
      bit         full;
      b  = new[FS];
      er = new[FS];
      for (int f = 0; f < 16; f++) begin
         drain();
         rand_ready = 1;
         repeat ($urandom_range(0, 3)) do_byte(8'($urandom), 1'b0, 1'b0);
         ph = 1'($urandom);
         do_sync(ph, 1'($urandom_range(0, 1)));
         vectors++;
         if (dec_hunt !== 1'b0 || dec_phase_sel !== ph) begin
            miscompares++;
            $display("FAIL rand_sync: frame %0d got hunt=%b ph=%b, need 0 %b",
                     f, dec_hunt, dec_phase_sel, ph);
         end
         full = ($urandom_range(0, 9) < 7);
         n    = full ? FS : $urandom_range(0, FS - 1);
         for (int i = 0; i < FS; i++) begin
            b[i]  = 8'($urandom);
            er[i] = ($urandom_range(0, 3) == 0);
         end
         expect_frame(b, er, n);
         for (int i = 0; i < n; i++) begin
            do_idle($urandom_range(0, 4), 1);
            do_byte(b[i], er[i], 1'($urandom_range(0, 1)));
         end
         if (!full) begin
            do_idle(TO, 1);
            if (n == 0) exp_drops++;
            else exp_frames++;
         end else begin
            exp_frames++;
         end
         vectors++;
         if (dec_hunt !== 1'b1 || stat_frames !== 16'(exp_frames) ||
             stat_drops !== 16'(exp_drops)) begin
            miscompares++;
            $display("FAIL rand_end: frame %0d got hunt=%b f=%0d d=%0d, need 1 %0d %0d",
                     f, dec_hunt, stat_frames, stat_drops, exp_frames, exp_drops);
         end
      end
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_rand: got %0d beats pending, need 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      m_axis.tready = 1'b0;
      do_sync(1'b1, 1'b0);
      do_byte(8'h77, 1'b0, 1'b0);
      do_byte(8'h88, 1'b0, 1'b0);
      areset = 1'b1;
      #1;
      exp_q.delete();
      exp_frames = 0;
      exp_drops  = 0;
      vectors++;
      if (m_axis.tvalid !== 1'b0 || dec_hunt !== 1'b1 || dec_phase_sel !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got v=%b hunt=%b ph=%b, need 0 1 0",
                  m_axis.tvalid, dec_hunt, dec_phase_sel);
      end
      vectors++;
      if (stat_frames !== 16'd0 || stat_drops !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_clear: got %0d/%0d, need 0/0", stat_frames, stat_drops);
      end
      @(posedge aclk);
      #1;
      areset        = 1'b0;
      m_axis.tready = 1'b1;
      do_idle(20, 0);
      vectors++;
      if (stat_frames !== 16'd0 || m_axis.tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset: got frames=%0d v=%b, need 0 0", stat_frames, m_axis.tvalid);
      end
   endtask

   initial begin
      test_reset();
      test_clean_frame(1'b0);
      test_clean_frame(1'b1);
      test_backpressure();
      test_timeout();
      test_empty_timeout_alias();
      test_random();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
